// File: rtl/div_pkg.sv
// +---------------------------------------------------------------------------+
// | div_pkg : execute-stage operation encodings shared by the mul/div units.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +---------------------------------------------------------------------------+
// | div_step : one radix-2 restoring division step on {rem, quo}.             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module div_step (
  input  logic [64:0] i_rem,
  input  logic [63:0] i_quo,
  input  logic [63:0] i_divisor,
  output logic [64:0] o_rem,
  output logic [63:0] o_quo
);

  logic [64:0] w_rem_sh;
  logic [63:0] w_quo_sh;

  always_comb begin
    w_rem_sh = {i_rem[63:0], i_quo[63]};
    w_quo_sh = {i_quo[62:0], 1'b0};
    o_rem    = w_rem_sh;
    o_quo    = w_quo_sh;
    if (w_rem_sh >= {1'b0, i_divisor}) begin
      o_rem    = w_rem_sh - {1'b0, i_divisor};
      o_quo[0] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/div.sv
// +---------------------------------------------------------------------------+
// | div : iterative RV64M divide/remainder unit, one quotient bit per cycle.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module div
  import div_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        div_word,
  input  logic        en,
  input  div_op       op,
  output logic        in_ready,
  output logic [63:0] out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [6:0] c_ITER_DW = 7'd64;
  localparam logic [6:0] c_ITER_W  = 7'd32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAL   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  div_op       r_op;
  logic        r_word, r_q_neg, r_r_neg;
  logic [64:0] r_rem;
  logic [63:0] r_quo, r_divisor;
  logic [6:0]  r_count;

  logic        w_signed, w_s1, w_s2, w_div_zero, w_ovf, w_is_quo, w_neg;
  logic [63:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_min;
  logic [63:0] w_res, w_val, w_quo_next;
  logic [64:0] w_rem_next;

  // Operand preparation for the accept cycle
  always_comb begin
    w_signed = (op == DIV) || (op == REM);
    w_a_ext  = in1;
    w_b_ext  = in2;
    if (div_word) begin
      w_a_ext = {{32{w_signed & in1[31]}}, in1[31:0]};
      w_b_ext = {{32{w_signed & in2[31]}}, in2[31:0]};
    end
    w_s1       = w_signed & w_a_ext[63];
    w_s2       = w_signed & w_b_ext[63];
    w_a_abs    = w_s1 ? (~w_a_ext + 64'd1) : w_a_ext;
    w_b_abs    = w_s2 ? (~w_b_ext + 64'd1) : w_b_ext;
    w_div_zero = (w_b_ext == 64'd0);
    w_min      = div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    w_ovf      = w_signed && (w_a_ext == w_min) && (&w_b_ext);
  end

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (en) w_state_next = (w_div_zero || w_ovf) ? FINAL : CAL;
      CAL:     if (r_count == 7'd1) w_state_next = FINAL;
      FINAL:   if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= DIV;
      r_word    <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_rem     <= 65'd0;
      r_quo     <= 64'd0;
      r_divisor <= 64'd0;
      r_count   <= 7'd0;
    end else if (r_state == IDLE) begin
      if (en) begin
        r_op      <= op;
        r_word    <= div_word;
        r_divisor <= w_b_abs;
        r_count   <= div_word ? c_ITER_W : c_ITER_DW;
        if (w_div_zero) begin
          r_quo   <= '1;
          r_rem   <= {1'b0, w_a_ext};
          r_q_neg <= 1'b0;
          r_r_neg <= 1'b0;
        end else if (w_ovf) begin
          r_quo   <= w_a_ext;
          r_rem   <= 65'd0;
          r_q_neg <= 1'b0;
          r_r_neg <= 1'b0;
        end else begin
          // Word dividends sit in the top half so 32 shifts consume them
          r_quo   <= div_word ? {w_a_abs[31:0], 32'd0} : w_a_abs;
          r_rem   <= 65'd0;
          r_q_neg <= w_s1 ^ w_s2;
          r_r_neg <= w_s1;
        end
      end
    end else if (r_state == CAL) begin
      r_rem   <= w_rem_next;
      r_quo   <= w_quo_next;
      r_count <= r_count - 7'd1;
    end
  end

  always_comb begin
    w_is_quo  = (r_op == DIV) || (r_op == DIVU);
    w_res     = w_is_quo ? r_quo : r_rem[63:0];
    w_neg     = w_is_quo ? r_q_neg : r_r_neg;
    w_val     = w_neg ? (~w_res + 64'd1) : w_res;
    out       = r_word ? {{32{w_val[31]}}, w_val[31:0]} : w_val;
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == FINAL);
  end

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// +---------------------------------------------------------------------------+
// | tb_div : directed self-checking bench for the div unit.                   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_div;
  import div_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [63:0] in1, in2;
  logic        div_word;
  logic        en;
  div_op       op;
  logic        in_ready;
  logic [63:0] out;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  div dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in1       (in1),
    .in2       (in2),
    .div_word  (div_word),
    .en        (en),
    .op        (op),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request; returns #1 after the accept edge with inputs scrambled
  task automatic start_op(input div_op o, input logic w, input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    op       = o;
    div_word = w;
    in1      = a;
    in2      = b;
    en       = 1'b1;
    @(posedge clock);
    #1;
    en  = 1'b0;
    in1 = {$urandom(), $urandom()};
    in2 = {$urandom(), $urandom()};
  endtask

  // Edges after the accept edge until out_valid is seen (bounded)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input div_op o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_out, input int exp_lat);
    int lat;
    start_op(o, w, a, b);
    wait_valid(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_out"}, out, exp_out);
    @(posedge clock);
    #1;
    check_eq({tag, "_retire"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int lat;
    reset_n   = 1'b0;
    en        = 1'b0;
    out_ready = 1'b1;
    op        = DIV;
    div_word  = 1'b0;
    in1       = 64'd0;
    in2       = 64'd0;

    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_state", {out_valid, in_ready, out}, {1'b0, 1'b1, 64'd0});
    @(negedge clock);
    reset_n = 1'b1;

    // Basic signed/unsigned
    run_op("div_100_7",   DIV, 1'b0, 64'd100, 64'd7, 64'd14, 64);
    run_op("rem_100_7",   REM, 1'b0, 64'd100, 64'd7, 64'd2, 64);
    run_op("div_m100_7",  DIV, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64);
    run_op("rem_m100_7",  REM, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    run_op("divu_big",    DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 64);
    run_op("remu_big",    REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
           64'h7FFF_FFFF_FFFF_FFFE, 64);

    // Divide by zero
    run_op("divu_zero",   DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remu_zero",   REMU, 1'b0, 64'd5, 64'd0, 64'd5, 0);
    run_op("remw_zero",   REM, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 0);

    // Signed overflow
    run_op("div_ovf",     DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 0);
    run_op("rem_ovf",     REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    run_op("divw_ovf",    DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 0);

    // Word forms
    run_op("divuw_zext",  DIVU, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 32);
    run_op("divw_m7_2",   DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32);
    run_op("remw_m7_2",   REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32);

    // Backpressure: result held, en ignored, en at retire not accepted
    out_ready = 1'b0;
    start_op(DIV, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    check_eq("bp_lat", 64'(lat), 64'd64);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      en  = 1'b1;
      op  = DIVU;
      in1 = {$urandom(), $urandom()};
      in2 = 64'd0;
      @(posedge clock);
      #1;
      check_eq("bp_hold", {63'd0, out_valid}, 64'd1);
      check_eq("bp_out", out, 64'd14);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    en = 1'b0;
    check_eq("bp_retire", {62'd0, out_valid, in_ready}, 64'd1);
    @(posedge clock);
    #1;
    check_eq("bp_no_accept", {62'd0, out_valid, in_ready}, 64'd1);

    // Asynchronous reset in the middle of a computation
    start_op(DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (20) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid", {out_valid, in_ready, out}, {1'b0, 1'b1, 64'd0});
    @(negedge clock);
    reset_n = 1'b1;
    run_op("divu_9_3",    DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 64);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
